ysyx_201979054_axi_wb_burst: RTL and testbench

YSYX_201979054_AXI_WB_BURST -- requirements
Module: ysyx_201979054_axi_wb_burst

---
 rtl/ysyx_201979054_axi_pkg.sv | 24 ++
 rtl/ysyx_201979054_piso_shifter.sv | 29 ++
 rtl/ysyx_201979054_axi_wb_burst.sv | 145 ++++++++++++++
 tb/tb_ysyx_201979054_axi_wb_burst.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_201979054_axi_pkg.sv
// Shared types and AXI encodings for the cache-line writeback burst engine.
package ysyx_201979054_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wb_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // AxSIZE encoding for a beat of the given byte count (power of two).
  function automatic logic [2:0] axi_size(input int bytes);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == bytes) s = 3'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/ysyx_201979054_piso_shifter.sv
// Parallel-in serial-out line buffer: loads a whole line, presents the
// lowest beat, and drops one beat per shift.
module ysyx_201979054_piso_shifter #(
  parameter int BLOCK_WIDTH = 512,
  parameter int BEAT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic                   load_i,
  input  logic [BLOCK_WIDTH-1:0] data_i,
  input  logic                   shift_i,
  output logic [BEAT_WIDTH-1:0]  beat_o
);

  logic [BLOCK_WIDTH-1:0] block_q;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      block_q <= '0;
    end else if (load_i) begin
      block_q <= data_i;
    end else if (shift_i) begin
      block_q <= block_q >> BEAT_WIDTH;
    end
  end

  assign beat_o = block_q[BEAT_WIDTH-1:0];

endmodule

// File: rtl/ysyx_201979054_axi_wb_burst.sv
// Writes one cache line to an AXI slave as a single INCR burst.
//   state | meaning
//   IDLE  | waiting for start, line not held
//   ADDR  | AW presented, waiting for awready
//   DATA  | streaming beats on W, counter = current beat
//   RESP  | waiting for the write response
module ysyx_201979054_axi_wb_burst
  import ysyx_201979054_axi_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int BLOCK_WIDTH    = 512
) (
  input  logic                        clk,
  input  logic                        arstn,
  input  logic                        start,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_addr,
  input  logic [BLOCK_WIDTH-1:0]      i_data_block,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_error,
  output logic                        o_awvalid,
  input  logic                        i_awready,
  output logic [AXI_ADDR_WIDTH-1:0]   o_awaddr,
  output logic [7:0]                  o_awlen,
  output logic [2:0]                  o_awsize,
  output logic [1:0]                  o_awburst,
  output logic                        o_wvalid,
  input  logic                        i_wready,
  output logic [AXI_DATA_WIDTH-1:0]   o_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] o_wstrb,
  output logic                        o_wlast,
  input  logic                        i_bvalid,
  output logic                        o_bready,
  input  logic [1:0]                  i_bresp
);

  localparam int              BEATS     = BLOCK_WIDTH / AXI_DATA_WIDTH;
  localparam int              CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [2:0]      BEAT_SIZE = axi_size(AXI_DATA_WIDTH / 8);

  wb_state_e                 state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic                      awvalid_q;
  logic                      wvalid_q;
  logic                      wlast_q;
  logic                      bready_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      error_q;

  logic load;
  logic w_hs;

  assign load = (state_q == ST_IDLE) && start;
  assign w_hs = wvalid_q && i_wready;

  ysyx_201979054_piso_shifter #(
    .BLOCK_WIDTH (BLOCK_WIDTH),
    .BEAT_WIDTH  (AXI_DATA_WIDTH)
  ) u_piso (
    .clk     (clk),
    .arstn   (arstn),
    .load_i  (load),
    .data_i  (i_data_block),
    .shift_i (w_hs),
    .beat_o  (o_wdata)
  );

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q    <= i_addr;
            awvalid_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (i_awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wlast_q   <= (LAST_BEAT == '0);
            cnt_q     <= '0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (i_wready) begin
            if (cnt_q == LAST_BEAT) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= ST_RESP;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              wlast_q <= ((cnt_q + 1'b1) == LAST_BEAT);
            end
          end
        end
        ST_RESP: begin
          // o_done is raised here so it lands on the first IDLE cycle.
          if (i_bvalid) begin
            bready_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            error_q  <= (i_bresp != AXI_RESP_OKAY);
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_error   = error_q;
  assign o_awvalid = awvalid_q;
  assign o_awaddr  = addr_q;
  assign o_awlen   = 8'(BEATS - 1);
  assign o_awsize  = BEAT_SIZE;
  assign o_awburst = AXI_BURST_INCR;
  assign o_wvalid  = wvalid_q;
  assign o_wstrb   = '1;
  assign o_wlast   = wlast_q;
  assign o_bready  = bready_q;

endmodule

// File: tb/tb_ysyx_201979054_axi_wb_burst.sv
// Directed bench for the writeback burst engine with a scoreboarded AXI slave.
module tb_ysyx_201979054_axi_wb_burst;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int BW    = 512;
  localparam int BEATS = BW / DW;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic            clk;
  logic            arstn;
  logic            start;
  logic [AW-1:0]   i_addr;
  logic [BW-1:0]   i_data_block;
  logic            o_busy, o_done, o_error;
  logic            o_awvalid, i_awready;
  logic [AW-1:0]   o_awaddr;
  logic [7:0]      o_awlen;
  logic [2:0]      o_awsize;
  logic [1:0]      o_awburst;
  logic            o_wvalid, i_wready;
  logic [DW-1:0]   o_wdata;
  logic [DW/8-1:0] o_wstrb;
  logic            o_wlast;
  logic            i_bvalid, o_bready;
  logic [1:0]      i_bresp;

  ysyx_201979054_axi_wb_burst #(
    .AXI_DATA_WIDTH (DW),
    .AXI_ADDR_WIDTH (AW),
    .BLOCK_WIDTH    (BW)
  ) dut (
    .clk          (clk),
    .arstn        (arstn),
    .start        (start),
    .i_addr       (i_addr),
    .i_data_block (i_data_block),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_awvalid    (o_awvalid),
    .i_awready    (i_awready),
    .o_awaddr     (o_awaddr),
    .o_awlen      (o_awlen),
    .o_awsize     (o_awsize),
    .o_awburst    (o_awburst),
    .o_wvalid     (o_wvalid),
    .i_wready     (i_wready),
    .o_wdata      (o_wdata),
    .o_wstrb      (o_wstrb),
    .o_wlast      (o_wlast),
    .i_bvalid     (i_bvalid),
    .o_bready     (o_bready),
    .i_bresp      (i_bresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t         sb[$];
  logic [AW-1:0] exp_addr = '0;
  int            aw_stall = 0;
  int            aw_wait  = 0;
  logic          w_toggle = 1'b0;
  logic          force_bvalid = 1'b0;
  logic [1:0]    bresp_val = 2'b00;
  logic          b_pend = 1'b0;
  int            w_hs_cnt = 0;
  int            aw_cyc = 0;
  int            done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave model and monitor: inputs change on the falling edge, then the
  // handshakes that the next rising edge will complete are checked.
  initial begin : slave
    logic          stall_prev;
    logic [DW-1:0] prev_wdata;
    logic          prev_wlast;
    beat_t         e;
    i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_bresp = 2'b00;
    stall_prev = 1'b0; prev_wdata = '0; prev_wlast = 1'b0;
    forever begin
      @(negedge clk);
      if (o_awvalid) begin
        if (aw_wait < aw_stall) begin
          i_awready = 1'b0;
          aw_wait++;
        end else begin
          i_awready = 1'b1;
        end
      end else begin
        i_awready = 1'b0;
        aw_wait   = 0;
      end
      i_wready = w_toggle ? ~i_wready : 1'b1;
      i_bvalid = b_pend | force_bvalid;
      i_bresp  = bresp_val;

      if (o_done) done_cnt++;
      if (o_awvalid) begin
        aw_cyc++;
        check("awaddr", o_awaddr, exp_addr);
        check("awlen", o_awlen, 8'(BEATS - 1));
        check("awsize", o_awsize, 3'd2);
        check("awburst", o_awburst, 2'b01);
        check("wvalid_during_aw", o_wvalid, 1'b0);
      end
      if (o_wvalid) begin
        check("wstrb", o_wstrb, {(DW/8){1'b1}});
        if (stall_prev) begin
          check("wdata_stall_stable", o_wdata, prev_wdata);
          check("wlast_stall_stable", o_wlast, prev_wlast);
        end
        if (i_wready) begin
          w_hs_cnt++;
          if (sb.size() == 0) begin
            check("w_sb_empty", 64'(sb.size() == 0), 64'd0);
          end else begin
            e = sb.pop_front();
            check("wdata", o_wdata, e.data);
            check("wlast", o_wlast, e.last);
          end
          if (o_wlast) b_pend = 1'b1;
        end
      end
      stall_prev = o_wvalid && !i_wready;
      prev_wdata = o_wdata;
      prev_wlast = o_wlast;
      if (o_bready && i_bvalid) b_pend = 1'b0;
    end
  end

  int t_start;

  task automatic start_burst(input logic [AW-1:0] addr, input logic [DW-1:0] base);
    logic [BW-1:0] blk;
    beat_t         e;
    exp_addr = addr;
    w_hs_cnt = 0;
    aw_cyc   = 0;
    for (int k = 0; k < BEATS; k++) begin
      blk[k*DW +: DW] = base + DW'(k);
      e.data = base + DW'(k);
      e.last = (k == BEATS - 1);
      sb.push_back(e);
    end
    @(negedge clk);
    i_addr = addr; i_data_block = blk; start = 1'b1;
    t_start = cyc;
    @(negedge clk);
    start = 1'b0; i_addr = '0; i_data_block = '0;
  endtask

  task automatic wait_done(output int lat);
    int n;
    n = 0;
    while (!o_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", o_done, 1'b1);
    lat = cyc - t_start;
  endtask

  int lat;
  int d0;

  initial begin : main
    arstn = 1'b0; start = 1'b0; i_addr = '0; i_data_block = '0;
    #1;
    check("rst_busy", o_busy, 1'b0);
    check("rst_awvalid", o_awvalid, 1'b0);
    check("rst_wvalid", o_wvalid, 1'b0);
    check("rst_bready", o_bready, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_error", o_error, 1'b0);
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    repeat (3) @(negedge clk);
    check("release_no_burst", {o_busy, o_awvalid}, 2'b00);

    // Always-ready slave, reference line.
    start_burst(32'h8000_0040, 32'h0000_1000);
    wait_done(lat);
    check("lat_ready", lat, 19);
    check("aw_cycles_ready", aw_cyc, 1);
    check("error_okay", o_error, 1'b0);
    @(negedge clk);
    check("done_pulse_width", o_done, 1'b0);
    check("idle_busy", o_busy, 1'b0);
    check("sb_drained_1", sb.size(), 0);
    check("w_count_1", w_hs_cnt, BEATS);

    // awready held off for five cycles.
    aw_stall = 5;
    start_burst(32'h1234_5600, 32'hA5A5_0000);
    wait_done(lat);
    check("lat_aw_stall", lat, 24);
    check("aw_cycles_stall", aw_cyc, 6);
    aw_stall = 0;

    // wready toggling.
    w_toggle = 1'b1;
    start_burst(32'h0000_0800, 32'h5000_0000);
    wait_done(lat);
    check("w_count_toggle", w_hs_cnt, BEATS);
    check("sb_drained_toggle", sb.size(), 0);
    w_toggle = 1'b0;
    @(negedge clk);

    // SLVERR response, then OKAY clears it.
    bresp_val = 2'b10;
    start_burst(32'h0000_0C00, 32'h7700_0000);
    wait_done(lat);
    check("error_slverr", o_error, 1'b1);
    bresp_val = 2'b00;
    start_burst(32'h0000_1000, 32'h8800_0000);
    check("error_held", o_error, 1'b1);
    wait_done(lat);
    check("error_cleared", o_error, 1'b0);
    check("lat_after_err", lat, 19);

    // Reset while beat 7 is on the bus.
    start_burst(32'h0000_2000, 32'h9900_0000);
    d0 = 0;
    while (w_hs_cnt < 7 && d0 < 200) begin
      @(posedge clk);
      d0++;
    end
    #2;
    check("beat7_data", o_wdata, 32'h9900_0007);
    check("beat7_valid", o_wvalid, 1'b1);
    arstn = 1'b0;
    #1;
    check("rst_mid_awvalid", o_awvalid, 1'b0);
    check("rst_mid_wvalid", o_wvalid, 1'b0);
    check("rst_mid_bready", o_bready, 1'b0);
    check("rst_mid_busy", o_busy, 1'b0);
    check("rst_mid_done", o_done, 1'b0);
    check("rst_mid_awaddr", o_awaddr, 32'h0);
    check("rst_mid_wdata", o_wdata, 32'h0);
    sb.delete();
    b_pend = 1'b0;
    #3;
    arstn = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_release_idle", {o_busy, o_awvalid, o_wvalid}, 3'b000);
    start_burst(32'h0000_3000, 32'hBB00_0000);
    wait_done(lat);
    check("lat_after_reset", lat, 19);
    check("sb_drained_reset", sb.size(), 0);

    // start and bvalid during DATA must both be ignored.
    d0 = done_cnt;
    start_burst(32'h0000_4000, 32'hCC00_0000);
    repeat (3) @(negedge clk);
    check("in_data", o_wvalid, 1'b1);
    start = 1'b1; i_addr = 32'hDEAD_0000; i_data_block = '1;
    force_bvalid = 1'b1; bresp_val = 2'b10;
    @(negedge clk);
    start = 1'b0; i_addr = '0; i_data_block = '0;
    repeat (3) @(negedge clk);
    force_bvalid = 1'b0; bresp_val = 2'b00;
    wait_done(lat);
    check("lat_ignore", lat, 19);
    check("error_ignore", o_error, 1'b0);
    repeat (25) @(negedge clk);
    check("done_once", done_cnt - d0, 1);
    check("no_restart", o_busy, 1'b0);
    check("w_count_ignore", w_hs_cnt, BEATS);
    check("sb_drained_ignore", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
